// File: rtl/periph_gpio_pkg.sv
// Shared register offsets and APB FSM encoding for the GPIO peripheral.
package periph_gpio_pkg;

   localparam logic [4:0] GPIO_OFS_OUT      = 5'h00;
   localparam logic [4:0] GPIO_OFS_OE       = 5'h04;
   localparam logic [4:0] GPIO_OFS_IN       = 5'h08;
   localparam logic [4:0] GPIO_OFS_INT_EN   = 5'h0C;
   localparam logic [4:0] GPIO_OFS_INT_STAT = 5'h10;
   localparam logic [4:0] GPIO_OFS_SET      = 5'h14;
   localparam logic [4:0] GPIO_OFS_CLR      = 5'h18;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} apb_state_e;

endpackage

// File: rtl/periph_gpio_sync.sv
// Pad input synchronizer: two-flop sync plus a history flop for rising-edge detect.
module periph_gpio_sync #(
   parameter int GPIO = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [GPIO-1:0] pad,
   output logic [GPIO-1:0] sync,
   output logic [GPIO-1:0] rise
);

   logic [GPIO-1:0] meta;
   logic [GPIO-1:0] prev;

   // all three stages clear together so reset never fakes an edge
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= '0;
         sync <= '0;
         prev <= '0;
      end else begin
         meta <= pad;
         sync <= meta;
         prev <= sync;
      end
   end

   assign rise = sync & ~prev;

endmodule

// File: rtl/periph_gpio_apb.sv
// APB GPIO controller: one-wait-state APB slave, pad sync, rising-edge level irq.
// Define PERIPH_GPIO_ATOMIC_EN to add the OUT_SET/OUT_CLR write-only registers.
module periph_gpio_apb
   import periph_gpio_pkg::*;
#(
   parameter int PADDR = 32,
   parameter int PDATA = 32,
   parameter int GPIO  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             psel,
   input  logic             penable,
   input  logic             pwrite,
   input  logic [PADDR-1:0] paddr,
   input  logic [PDATA-1:0] pwdata,
   output logic [PDATA-1:0] prdata,
   output logic             pready,
   output logic             pslverr,
   input  logic [GPIO-1:0]  gpio_in,
   output logic [GPIO-1:0]  gpio_out,
   output logic [GPIO-1:0]  gpio_oe,
   output logic             irq
);

   if (GPIO > PDATA) begin : g_width_chk
      $error("periph_gpio_apb: GPIO must not exceed PDATA");
   end

   apb_state_e      state, nxt;
   logic [GPIO-1:0] sync, rise;
   logic [GPIO-1:0] int_en, int_stat, clr, rd, wd;
   logic [4:0]      ofs;
   logic            mapped, err, wr_ok;
   logic            unused_ok;

   assign unused_ok = ^{paddr, pwdata};
   assign ofs       = {paddr[4:2], 2'b00};
   assign wd        = pwdata[GPIO-1:0];

   periph_gpio_sync #(.GPIO(GPIO)) u_sync (
      .clk  (clk),
      .rst  (rst),
      .pad  (gpio_in),
      .sync (sync),
      .rise (rise)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (psel && !penable) nxt = SETUP;
         SETUP:   if (!psel) nxt = IDLE;
                  else if (penable) nxt = ACCESS;
         ACCESS:  nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      mapped = 1'b1;
      rd     = '0;
      case (ofs)
         GPIO_OFS_OUT:      rd = gpio_out;
         GPIO_OFS_OE:       rd = gpio_oe;
         GPIO_OFS_IN:       rd = sync;
         GPIO_OFS_INT_EN:   rd = int_en;
         GPIO_OFS_INT_STAT: rd = int_stat;
`ifdef PERIPH_GPIO_ATOMIC_EN
         GPIO_OFS_SET, GPIO_OFS_CLR: rd = '0;
`endif
         default:           mapped = 1'b0;
      endcase
      err = !mapped || (pwrite && ofs == GPIO_OFS_IN);
   end

   always_comb begin
      pready  = (state == ACCESS);
      pslverr = pready && err;
      prdata  = '0;
      if (pready && !err) prdata[GPIO-1:0] = rd;
   end

   assign wr_ok = (state == ACCESS) && pwrite && !err;
   assign clr   = (wr_ok && ofs == GPIO_OFS_INT_STAT) ? wd : '0;

   // set term is OR-ed after the clear so a coincident edge wins
   always_ff @(posedge clk) begin
      if (rst) begin
         gpio_out <= '0;
         gpio_oe  <= '0;
         int_en   <= '0;
         int_stat <= '0;
         irq      <= 1'b0;
      end else begin
         int_stat <= (int_stat & ~clr) | (rise & int_en);
         irq      <= |(int_stat & int_en);
         if (wr_ok) begin
            case (ofs)
               GPIO_OFS_OUT:    gpio_out <= wd;
               GPIO_OFS_OE:     gpio_oe  <= wd;
               GPIO_OFS_INT_EN: int_en   <= wd;
`ifdef PERIPH_GPIO_ATOMIC_EN
               GPIO_OFS_SET:    gpio_out <= gpio_out | wd;
               GPIO_OFS_CLR:    gpio_out <= gpio_out & ~wd;
`endif
               default: ;
            endcase
         end
      end
   end

endmodule
